uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one framed-string UART transmitter (the `&&data&&` string handler) between N independent requesters.
- Arbitrates round-robin, latches the winning string and length, and launches the transmitter with a one-cycle request.
- Waits for completion, then returns a per-requester ack, or an error ack on bad length or timeout.
- Sits between application blocks (measurement report, status, echo) and the UART string handler.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STR_W, 1096, payload bus width per requester; byte k occupies bits [8k+7:8k].
- MAX_LEN, 137, largest legal byte count (STR_W/8).
- TIMEOUT_CYC, 24'd5_000_000, cycles allowed from launch to tx_done before abort.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  level request per requester; held until its ack
- req_string  in  NUM_REQ*STR_W  payloads; requester i at [i*STR_W +: STR_W]
- req_length  in  NUM_REQ*8  byte counts; requester i at [i*8 +: 8]
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_err  out  NUM_REQ  one-cycle pulse, coincident with req_ack, when the job failed
- grant  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle
- sched_busy  out  1  high in every state except IDLE
- tx_string  out  STR_W  to string handler, latched payload
- tx_length  out  8  to string handler, latched length
- tx_req  out  1  to string handler, one-cycle launch pulse
- tx_busy  in  1  from string handler
- tx_done  in  1  from string handler, one-cycle completion pulse

Behaviour:
- Reset values:
  - all outputs 0;
  - RR pointer = 0;
  - state = IDLE;
  - timeout counter = 0.
- Reset mid-transfer aborts immediately: no ack is issued and grant clears.
- Clock and reset: one clock domain; reset is asynchronous, active-low (sys_rst_n).
- State machine: IDLE, ARB, CHECK, LAUNCH, WAIT_DONE, ACK (one-hot).
- IDLE -> ARB when |req_valid is high.
- ARB:
  - Winner = first set bit of req_valid searching from the RR pointer upward, wrapping modulo NUM_REQ.
  - Latch winner index, tx_string and tx_length. Set grant one-hot.
  - -> CHECK.
- CHECK:
  - If latched length == 0 or > MAX_LEN, set the error flag -> ACK. The transmitter is never touched.
  - Otherwise -> LAUNCH.
- LAUNCH:
  - Hold while tx_busy = 1.
  - When tx_busy = 0, assert tx_req for exactly one cycle, clear the timeout counter -> WAIT_DONE.
- WAIT_DONE:
  - The counter increments each cycle.
  - tx_done = 1 -> ACK with the error flag clear.
  - Counter reaches TIMEOUT_CYC-1 with no tx_done -> ACK with the error flag set.
  - If tx_done arrives in the same cycle as the timeout, success wins.
- ACK:
  - req_ack[idx] = 1 for one cycle; req_err[idx] = error flag.
  - grant clears on exit. RR pointer = (idx+1) mod NUM_REQ.
  - -> IDLE.
- Transaction latency, arbitration side: valid high to tx_req is 4 cycles (IDLE, ARB, CHECK, LAUNCH) when the transmitter is free.
- Transaction latency, completion side: tx_done to req_ack is 1 cycle.
- tx_string and tx_length stay stable from ARB until the next ARB. Requester inputs may change after grant without effect.
- Requester protocol:
  - A requester must drop req_valid in the cycle after its ack; the IDLE cycle guarantees no re-grant from a stale level.
  - req_valid dropped before grant means the request is simply not served.
  - req_valid dropped after grant has no effect; the job completes and is acked.
- A tx_done pulse outside WAIT_DONE is ignored.
- tx_req is never asserted while tx_busy = 1.
- The error flag and index are cleared on entry to ARB.

Test Plan:
- Single requester 1: length 5, payload "HELLO", transmitter model with tx_done 100 cycles after tx_req -> tx_req exactly 1 cycle at valid+4. tx_string[39:0] equals "HELLO" in that byte order, tx_length = 5. grant = 4'b0010 throughout. req_ack = 4'b0010, req_err = 0 one cycle after tx_done.
- Fairness: requesters 0, 1 and 3 held valid continuously and reasserted after each ack -> grant order 0, 1, 3, 0, 1, 3. No requester is served twice before the others once.
- Bad length: requester 2 length 0, then length 200 -> tx_req never asserted. req_ack[2] and req_err[2] pulse together 3 cycles after valid each time.
- Timeout: TIMEOUT_CYC = 50, model never returns tx_done -> ack with req_err = 1 exactly 50 cycles after tx_req. Then return to IDLE and serve the next requester normally.
- Busy transmitter: tx_busy held high 30 cycles when LAUNCH is entered -> tx_req deferred until the first cycle tx_busy = 0. A stray tx_done pulse during IDLE has no effect.
- Reset mid-WAIT_DONE: assert sys_rst_n low -> grant, tx_req, req_ack and sched_busy are 0 immediately. After release, the RR pointer restarts at 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between requesters, the scheduler and the framed-string UART transmitter.
// master = scheduler view, slave = requesters plus string handler view.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int STR_W   = 1096
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*STR_W-1:0] req_string;
    logic [NUM_REQ*8-1:0]     req_length;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NUM_REQ-1:0]       req_err;
    logic [NUM_REQ-1:0]       grant;
    logic                     sched_busy;
    logic [STR_W-1:0]         tx_string;
    logic [7:0]               tx_length;
    logic                     tx_req;
    logic                     tx_busy;
    logic                     tx_done;

    modport master (
        input  req_valid, req_string, req_length, tx_busy, tx_done,
        output req_ack, req_err, grant, sched_busy, tx_string, tx_length, tx_req
    );

    modport slave (
        output req_valid, req_string, req_length, tx_busy, tx_done,
        input  req_ack, req_err, grant, sched_busy, tx_string, tx_length, tx_req
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one framed-string UART transmitter between NUM_REQ
// requesters; latches the winning job, launches it, and acks success/error per requester.
module uart_tx_scheduler #(
    parameter int          NUM_REQ     = 4,
    parameter int          STR_W       = 1096,
    parameter int          MAX_LEN     = 137,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input logic                 sys_clk,
    input logic                 sys_rst_n,
    uart_tx_scheduler_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ARB    = 6'b000010,
        S_CHECK  = 6'b000100,
        S_LAUNCH = 6'b001000,
        S_WAIT   = 6'b010000,
        S_ACK    = 6'b100000
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        rr_q, idx_q;
    logic                 err_q;
    logic [23:0]          cnt_q;
    logic [NUM_REQ-1:0]   grant_q, ack_q, rerr_q;
    logic [STR_W-1:0]     str_q;
    logic [7:0]           len_q;
    logic                 tx_req_q;

    logic [IW-1:0]        win_idx;
    logic                 win_vld;
    int                   pos;

    // Walk from the highest offset down so the closest requester to rr_q is written last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        pos     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(rr_q) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (bus.req_valid[pos]) begin
                win_vld = 1'b1;
                win_idx = IW'(pos);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            rerr_q   <= '0;
            str_q    <= '0;
            len_q    <= '0;
            tx_req_q <= 1'b0;
        end else begin
            tx_req_q <= 1'b0;
            ack_q    <= '0;
            rerr_q   <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    // A request withdrawn before grant is simply not served.
                    if (win_vld) begin
                        idx_q   <= win_idx;
                        str_q   <= bus.req_string[win_idx*STR_W +: STR_W];
                        len_q   <= bus.req_length[win_idx*8 +: 8];
                        grant_q <= NUM_REQ'(1) << win_idx;
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (len_q == 8'd0 || len_q > 8'(MAX_LEN)) begin
                        err_q         <= 1'b1;
                        ack_q[idx_q]  <= 1'b1;
                        rerr_q[idx_q] <= 1'b1;
                        state_q       <= S_ACK;
                    end else begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!bus.tx_busy) begin
                        tx_req_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // tx_done is tested first so a completion on the timeout cycle still succeeds.
                    if (bus.tx_done) begin
                        ack_q[idx_q] <= 1'b1;
                        state_q      <= S_ACK;
                    end else if (cnt_q == TIMEOUT_CYC - 24'd1) begin
                        err_q         <= 1'b1;
                        ack_q[idx_q]  <= 1'b1;
                        rerr_q[idx_q] <= 1'b1;
                        state_q       <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                S_ACK: begin
                    grant_q <= '0;
                    rr_q    <= (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack    = ack_q;
    assign bus.req_err    = rerr_q;
    assign bus.grant      = grant_q;
    assign bus.sched_busy = (state_q != S_IDLE);
    assign bus.tx_string  = str_q;
    assign bus.tx_length  = len_q;
    assign bus.tx_req     = tx_req_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: unit A with a 100-cycle transmitter model,
// unit B with a 50-cycle timeout and a hand-driven transmitter.
module tb_uart_tx_scheduler;
    localparam int NR = 4;
    localparam int SW = 1096;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_tx_scheduler_if #(.NUM_REQ(NR), .STR_W(SW)) bus_a ();
    uart_tx_scheduler_if #(.NUM_REQ(NR), .STR_W(SW)) bus_b ();

    uart_tx_scheduler #(.NUM_REQ(NR), .STR_W(SW), .MAX_LEN(137)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_a.master));
    uart_tx_scheduler #(.NUM_REQ(NR), .STR_W(SW), .MAX_LEN(137), .TIMEOUT_CYC(24'd50)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_b.master));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Transmitter model for unit A: busy after tx_req, tx_done 100 cycles later.
    // Inputs change only at negedges so what is read here is what the DUT sampled.
    int   a_rem = 0;
    logic a_busy = 1'b0;
    logic man_busy = 1'b0;
    logic stray_done = 1'b0;
    int   done_cyc = -1;
    int   viol = 0;
    logic done_n;
    always @(negedge sys_clk) begin
        if (bus_a.tx_req && bus_a.tx_busy) viol++;
        done_n = 1'b0;
        if (a_rem > 0) begin
            a_rem--;
            if (a_rem == 0) begin
                done_n   = 1'b1;
                a_busy   = 1'b0;
                done_cyc = cyc;
            end
        end
        if (bus_a.tx_req) begin
            a_busy = 1'b1;
            a_rem  = 100;
        end
        if (stray_done) begin
            done_n     = 1'b1;
            stray_done = 1'b0;
        end
        bus_a.tx_done = done_n;
        bus_a.tx_busy = a_busy | man_busy;
    end

    task automatic wait_ack(input string tag, input int bound, input logic [3:0] exp_g,
                            output int ack_c, output int req_c, output int nreq, output int gbad,
                            output logic [3:0] ack, output logic [3:0] err);
        ack_c = -1; req_c = -1; nreq = 0; gbad = 0; ack = '0; err = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sys_clk);
            if (bus_a.tx_req) begin
                nreq++;
                if (req_c < 0) req_c = cyc;
            end
            if (bus_a.grant != 4'b0 && bus_a.grant != exp_g) gbad++;
            if (req_c >= 0 && bus_a.grant != exp_g) gbad++;
            if (bus_a.req_ack != 4'b0) begin
                ack_c = cyc;
                ack   = bus_a.req_ack;
                err   = bus_a.req_err;
                break;
            end
        end
        if (ack_c < 0) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    string hello = "HELLO";
    logic [3:0] ford [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    initial begin
        int t0, ac, rc, nr, gb, cnt, trq;
        logic [3:0] ak, er;

        bus_a.req_valid = '0; bus_a.req_string = '0; bus_a.req_length = '0;
        bus_b.req_valid = '0; bus_b.req_string = '0; bus_b.req_length = '0;
        bus_b.tx_busy = 1'b0; bus_b.tx_done = 1'b0;
        bus_a.req_length = {8'd3, 8'd4, 8'd5, 8'd3};
        bus_b.req_length = {8'd3, 8'd4, 8'd5, 8'd4};
        for (int k = 0; k < 5; k++) bus_a.req_string[1*SW + 8*k +: 8] = hello[k];

        // reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_grant", bus_a.grant, 0);
        chk("rst_ack", bus_a.req_ack, 0);
        chk("rst_err", bus_a.req_err, 0);
        chk("rst_busy", bus_a.sched_busy, 0);
        chk("rst_txreq", bus_a.tx_req, 0);
        chk("rst_txlen", bus_a.tx_length, 0);
        chk("rst_txstr_or", longint'(|bus_a.tx_string), 0);
        tick();
        sys_rst_n = 1'b1;
        tick();

        // fairness: 0,1,3 held, dropped one cycle after each ack then reasserted
        bus_a.req_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_ack("fair", 400, ford[k], ac, rc, nr, gb, ak, er);
            chk($sformatf("fair_ack%0d", k), ak, ford[k]);
            chk($sformatf("fair_err%0d", k), er, 0);
            chk($sformatf("fair_grant%0d", k), gb, 0);
            tick();
            bus_a.req_valid = bus_a.req_valid & ~ak;
            tick();
            if (k < 5) bus_a.req_valid = bus_a.req_valid | ak;
        end
        bus_a.req_valid = '0;
        repeat (3) tick();

        // single requester 1, "HELLO", input corrupted after grant
        bus_a.req_valid[1] = 1'b1;
        t0 = cyc;
        repeat (3) tick();
        bus_a.req_string[1*SW +: 8] = 8'h58;
        wait_ack("hello", 300, 4'b0010, ac, rc, nr, gb, ak, er);
        chk("hello_txreq_lat", rc - t0, 4);
        chk("hello_txreq_cnt", nr, 1);
        chk("hello_grant", gb, 0);
        chk("hello_ack", ak, 4'b0010);
        chk("hello_err", er, 0);
        chk("hello_done_to_ack", ac - done_cyc, 1);
        chk("hello_req_to_ack", ac - rc, 101);
        chk("hello_str", bus_a.tx_string[39:0], 40'h4F4C4C4548);
        chk("hello_len", bus_a.tx_length, 5);
        tick();
        bus_a.req_valid[1] = 1'b0;
        bus_a.req_string[1*SW +: 8] = 8'h48;
        @(negedge sys_clk);
        chk("hello_grant_clr", bus_a.grant, 0);
        repeat (2) tick();

        // bad lengths on requester 2
        for (int k = 0; k < 2; k++) begin
            bus_a.req_length[2*8 +: 8] = (k == 0) ? 8'd0 : 8'd200;
            bus_a.req_valid[2] = 1'b1;
            t0 = cyc;
            wait_ack("badlen", 20, 4'b0100, ac, rc, nr, gb, ak, er);
            chk($sformatf("badlen%0d_lat", k), ac - t0, 3);
            chk($sformatf("badlen%0d_ack", k), ak, 4'b0100);
            chk($sformatf("badlen%0d_err", k), er, 4'b0100);
            chk($sformatf("badlen%0d_txreq", k), nr, 0);
            chk($sformatf("badlen%0d_grant", k), gb, 0);
            tick();
            bus_a.req_valid[2] = 1'b0;
            repeat (2) tick();
        end
        bus_a.req_length[2*8 +: 8] = 8'd4;

        // busy transmitter: LAUNCH sees tx_busy for 30 cycles
        man_busy = 1'b1;
        bus_a.req_valid[0] = 1'b1;
        t0 = cyc;
        repeat (33) tick();
        man_busy = 1'b0;
        wait_ack("busy", 300, 4'b0001, ac, rc, nr, gb, ak, er);
        chk("busy_txreq_lat", rc - t0, 34);
        chk("busy_txreq_cnt", nr, 1);
        chk("busy_ack", ak, 4'b0001);
        chk("busy_err", er, 0);
        tick();
        bus_a.req_valid[0] = 1'b0;
        repeat (2) tick();

        // stray tx_done while idle
        stray_done = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge sys_clk);
            if (bus_a.req_ack != 4'b0 || bus_a.sched_busy || bus_a.grant != 4'b0) cnt++;
        end
        chk("stray_done_effect", cnt, 0);

        // unit B: timeout after 50 cycles, then a normal job
        tick();
        bus_b.req_valid[0] = 1'b1;
        trq = -1; ac = -1;
        for (int i = 0; i < 120 && ac < 0; i++) begin
            @(negedge sys_clk);
            if (bus_b.tx_req && trq < 0) trq = cyc;
            if (bus_b.req_ack != 4'b0) begin
                ac = cyc; ak = bus_b.req_ack; er = bus_b.req_err;
            end
        end
        chk("tmo_seen", longint'(ac >= 0 && trq >= 0), 1);
        chk("tmo_lat", ac - trq, 50);
        chk("tmo_ack", ak, 4'b0001);
        chk("tmo_err", er, 4'b0001);
        tick();
        bus_b.req_valid[0] = 1'b0;
        tick();
        bus_b.req_valid[1] = 1'b1;
        trq = -1;
        for (int i = 0; i < 20 && trq < 0; i++) begin
            @(negedge sys_clk);
            if (bus_b.tx_req) trq = cyc;
        end
        chk("tmo_next_txreq", longint'(trq >= 0), 1);
        repeat (3) tick();
        bus_b.tx_done = 1'b1;
        tick();
        bus_b.tx_done = 1'b0;
        ac = -1;
        for (int i = 0; i < 10 && ac < 0; i++) begin
            @(negedge sys_clk);
            if (bus_b.req_ack != 4'b0) begin
                ac = cyc; ak = bus_b.req_ack; er = bus_b.req_err;
            end
        end
        chk("tmo_next_lat", ac - trq, 4);
        chk("tmo_next_ack", ak, 4'b0010);
        chk("tmo_next_err", er, 0);
        tick();
        bus_b.req_valid[1] = 1'b0;

        // reset in the middle of WAIT_DONE on unit A (RR pointer is 1 beforehand)
        bus_a.req_valid[2] = 1'b1;
        trq = -1;
        for (int i = 0; i < 20 && trq < 0; i++) begin
            @(negedge sys_clk);
            if (bus_a.tx_req) trq = cyc;
        end
        chk("rstmid_txreq", longint'(trq >= 0), 1);
        repeat (3) tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rstmid_grant", bus_a.grant, 0);
        chk("rstmid_txreq_low", bus_a.tx_req, 0);
        chk("rstmid_ack", bus_a.req_ack, 0);
        chk("rstmid_busy", bus_a.sched_busy, 0);
        bus_a.req_valid = '0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (110) tick();
        bus_a.req_valid = 4'b1001;
        wait_ack("rr_restart", 300, 4'b0001, ac, rc, nr, gb, ak, er);
        chk("rr_restart_ack", ak, 4'b0001);
        chk("rr_restart_err", er, 0);
        tick();
        bus_a.req_valid = '0;
        repeat (3) tick();

        chk("txreq_while_busy", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
